// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: ASCII constants, parser
// states and the byte classifier used by the UART number parser.
package calc_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_MINUS = 8'h2D;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SIGN,
        P_DIGITS,
        P_SKIP
    } pstate_e;

    typedef enum logic [1:0] {
        CC_DIGIT,
        CC_DELIM,
        CC_MINUS,
        CC_ILLEGAL
    } char_class_e;

    // Classify one received byte for the token parser.
    function automatic char_class_e char_class(input logic [7:0] c);
        char_class_e cls;
        cls = CC_ILLEGAL;
        if ((c >= ASC_0) && (c <= ASC_9)) begin
            cls = CC_DIGIT;
        end else if ((c == ASC_SP) || (c == ASC_COMMA) ||
                     (c == ASC_CR) || (c == ASC_LF)) begin
            cls = CC_DELIM;
        end else if (c == ASC_MINUS) begin
            cls = CC_MINUS;
        end
        return cls;
    endfunction

endpackage

// File: rtl/num_idle_timer.sv
// Idle watchdog: reloads on activity, counts down while armed, and flags
// expiry exactly TIMEOUT_CYC cycles after the last load took effect.
module num_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Registered outputs downstream add one cycle, so the count stops two short.
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (TIMEOUT_CYC > 2) ? CNT_W'(TIMEOUT_CYC - 2) : '0;
    localparam bit TMO_EN = (TIMEOUT_CYC != 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = TMO_EN && tick && !load && (cnt_q == '0);

endmodule

// File: rtl/uart_num_parser.sv
// Turns the ASCII byte stream from the UART receiver into signed/unsigned
// binary numbers with overflow handling, idle flush and a token counter.
module uart_num_parser
    import calc_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_DIGITS  = 5,
    parameter int unsigned SIGNED_EN   = 1,
    parameter int unsigned SATURATE    = 1,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              cnt_clr,
    output logic              num_valid,
    output logic [DATA_W-1:0] num_value,
    output logic              num_ovf,
    output logic              num_err,
    output logic [7:0]        tok_cnt,
    output logic              busy
);

    localparam int unsigned ACC_W  = DATA_W + 4;
    localparam int unsigned DCNT_W = $clog2(MAX_DIGITS + 2);
    localparam bit SGN = (SIGNED_EN != 0);
    localparam bit SAT = (SATURATE != 0);

    localparam logic [ACC_W-1:0] LIM_UNS   = (ACC_W'(1) << DATA_W) - ACC_W'(1);
    localparam logic [ACC_W-1:0] LIM_NEG   = ACC_W'(1) << (DATA_W - 1);
    localparam logic [ACC_W-1:0] LIM_POS_S = LIM_NEG - ACC_W'(1);
    localparam logic [ACC_W-1:0] LIM_POS   = SGN ? LIM_POS_S : LIM_UNS;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(MAX_DIGITS);

    pstate_e            state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               num_valid_q, num_valid_d;
    logic [DATA_W-1:0]  num_value_q, num_value_d;
    logic               num_ovf_q, num_ovf_d;
    logic               num_err_q, num_err_d;
    logic [7:0]         tok_cnt_q, tok_cnt_d;
    logic               busy_q, busy_d;

    char_class_e        cls;
    logic [ACC_W-1:0]   digit_ext;
    logic [ACC_W-1:0]   lim_cur;
    logic [ACC_W-1:0]   acc_mul;
    logic               acc_mul_ovf;
    logic               first_ovf_pos;
    logic               first_ovf_neg;
    logic [DATA_W-1:0]  mag_lo;
    logic [DATA_W-1:0]  emit_val;
    logic               tok_done;
    logic               tok_bad;
    logic               tick;
    logic               tmo_c;

    // Arithmetic helpers; the accumulator is wide enough that acc*10+9 never wraps.
    assign cls           = char_class(rx_data);
    assign digit_ext     = ACC_W'(rx_data[3:0]);
    assign lim_cur       = neg_q ? LIM_NEG : LIM_POS;
    assign acc_mul       = (acc_q << 3) + (acc_q << 1) + digit_ext;
    assign acc_mul_ovf   = (dcnt_q >= DCNT_MAX) || (acc_mul > lim_cur);
    assign first_ovf_pos = digit_ext > LIM_POS;
    assign first_ovf_neg = digit_ext > LIM_NEG;
    assign mag_lo        = ovf_q ? lim_cur[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign emit_val      = neg_q ? (DATA_W'(0) - mag_lo) : mag_lo;
    assign tick          = (state_q != P_IDLE);

    num_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_valid),
        .tick     (tick),
        .expire_c (tmo_c)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        dcnt_d      = dcnt_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        num_valid_d = 1'b0;
        num_value_d = num_value_q;
        num_ovf_d   = 1'b0;
        num_err_d   = 1'b0;
        tok_cnt_d   = tok_cnt_q;
        tok_done    = 1'b0;
        tok_bad     = 1'b0;

        if (rx_valid) begin
            case (state_q)
                P_IDLE: begin
                    case (cls)
                        CC_DIGIT: begin
                            acc_d   = digit_ext;
                            dcnt_d  = DCNT_W'(1);
                            neg_d   = 1'b0;
                            ovf_d   = first_ovf_pos;
                            state_d = P_DIGITS;
                        end
                        CC_MINUS: begin
                            neg_d   = SGN;
                            state_d = SGN ? P_SIGN : P_SKIP;
                        end
                        CC_ILLEGAL: state_d = P_SKIP;
                        default: ;
                    endcase
                end
                P_SIGN: begin
                    case (cls)
                        CC_DIGIT: begin
                            acc_d   = digit_ext;
                            dcnt_d  = DCNT_W'(1);
                            ovf_d   = first_ovf_neg;
                            state_d = P_DIGITS;
                        end
                        CC_DELIM: tok_bad = 1'b1;
                        default:  state_d = P_SKIP;
                    endcase
                end
                P_DIGITS: begin
                    case (cls)
                        CC_DIGIT: begin
                            // Once overflowed, further digits are absorbed unchanged.
                            if (!ovf_q) begin
                                if (acc_mul_ovf) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    acc_d  = acc_mul;
                                    dcnt_d = dcnt_q + DCNT_W'(1);
                                end
                            end
                        end
                        CC_DELIM: tok_done = 1'b1;
                        default:  state_d = P_SKIP;
                    endcase
                end
                P_SKIP: begin
                    if (cls == CC_DELIM) begin
                        tok_bad = 1'b1;
                    end
                end
                default: state_d = P_IDLE;
            endcase
        end else if (tmo_c) begin
            // An idle line behaves like a delimiter in whatever state we are in.
            if (state_q == P_DIGITS) begin
                tok_done = 1'b1;
            end else if (state_q != P_IDLE) begin
                tok_bad = 1'b1;
            end
        end

        if (tok_done) begin
            if (ovf_q && !SAT) begin
                num_err_d = 1'b1;
            end else begin
                num_valid_d = 1'b1;
                num_value_d = emit_val;
                num_ovf_d   = ovf_q;
                tok_cnt_d   = tok_cnt_q + 8'd1;
            end
        end
        if (tok_bad) begin
            num_err_d = 1'b1;
        end
        if (tok_done || tok_bad) begin
            state_d = P_IDLE;
        end

        // Token context is meaningless outside a token; keep it clean in IDLE.
        if (state_d == P_IDLE) begin
            acc_d  = '0;
            dcnt_d = '0;
            neg_d  = 1'b0;
            ovf_d  = 1'b0;
        end

        if (cnt_clr) begin
            tok_cnt_d = '0;
        end
        busy_d = (state_d != P_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= P_IDLE;
            acc_q       <= '0;
            dcnt_q      <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            num_valid_q <= 1'b0;
            num_value_q <= '0;
            num_ovf_q   <= 1'b0;
            num_err_q   <= 1'b0;
            tok_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            dcnt_q      <= dcnt_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            num_valid_q <= num_valid_d;
            num_value_q <= num_value_d;
            num_ovf_q   <= num_ovf_d;
            num_err_q   <= num_err_d;
            tok_cnt_q   <= tok_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign num_valid = num_valid_q;
    assign num_value = num_value_q;
    assign num_ovf   = num_ovf_q;
    assign num_err   = num_err_q;
    assign tok_cnt   = tok_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_num_parser.sv
// Bench for uart_num_parser: three parameterisations share one byte stream,
// each with its own expected-event queue checked as pulses appear.
`timescale 1ns/1ps
module tb_uart_num_parser;

    localparam int unsigned DW   = 16;
    localparam int unsigned NDUT = 3;
    localparam int K_N = 0;
    localparam int K_V = 1;
    localparam int K_E = 2;

    logic clk = 1'b0;
    logic rst;
    logic rx_valid;
    logic [7:0] rx_data;
    logic cnt_clr;

    logic          nv [NDUT];
    logic          ne [NDUT];
    logic          no [NDUT];
    logic          bz [NDUT];
    logic [DW-1:0] val[NDUT];
    logic [7:0]    tc [NDUT];

    typedef struct {
        int          kind;
        logic [DW-1:0] val;
        logic        ovf;
        longint      cyc;
    } exp_t;

    typedef struct {
        string       txt;
        bit          b2b;
        int          k0; logic [DW-1:0] v0; logic o0;
        int          k1; logic [DW-1:0] v1; logic o1;
        int          k2; logic [DW-1:0] v2; logic o2;
    } vec_t;

    exp_t   expq[NDUT][$];
    vec_t   tbl[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    logic [DW-1:0] mdl_val[NDUT];
    logic [7:0]    mdl_tok[NDUT];
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: signed, saturating, short timeout. B: signed, error on overflow.
    // C: unsigned ('-' illegal), saturating, timeout disabled.
    uart_num_parser #(.DATA_W(16), .MAX_DIGITS(5), .SIGNED_EN(1), .SATURATE(1), .TIMEOUT_CYC(100)) dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .cnt_clr(cnt_clr),
        .num_valid(nv[0]), .num_value(val[0]), .num_ovf(no[0]), .num_err(ne[0]),
        .tok_cnt(tc[0]), .busy(bz[0]));
    uart_num_parser #(.DATA_W(16), .MAX_DIGITS(5), .SIGNED_EN(1), .SATURATE(0), .TIMEOUT_CYC(100)) dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .cnt_clr(cnt_clr),
        .num_valid(nv[1]), .num_value(val[1]), .num_ovf(no[1]), .num_err(ne[1]),
        .tok_cnt(tc[1]), .busy(bz[1]));
    uart_num_parser #(.DATA_W(16), .MAX_DIGITS(5), .SIGNED_EN(0), .SATURATE(1), .TIMEOUT_CYC(0)) dut_c (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .cnt_clr(cnt_clr),
        .num_valid(nv[2]), .num_value(val[2]), .num_ovf(no[2]), .num_err(ne[2]),
        .tok_cnt(tc[2]), .busy(bz[2]));

    function automatic void check(input string name, input int d, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, d, act, exp, $time);
        end
    endfunction

    function automatic void push_ev(input int d, input int k, input logic [DW-1:0] v,
                                    input logic o, input longint c);
        exp_t e;
        if (k == K_N) return;
        if (k == K_V) begin
            mdl_val[d] = v;
            mdl_tok[d] = mdl_tok[d] + 8'd1;
        end
        e.kind = k;
        e.val  = mdl_val[d];
        e.ovf  = (k == K_V) ? o : 1'b0;
        e.cyc  = c;
        expq[d].push_back(e);
    endfunction

    function automatic void add(input string t, input bit b,
                                input int k0, input int v0, input bit o0,
                                input int k1, input int v1, input bit o1,
                                input int k2, input int v2, input bit o2);
        vec_t r;
        r.txt = t; r.b2b = b;
        r.k0 = k0; r.v0 = DW'(v0); r.o0 = o0;
        r.k1 = k1; r.v1 = DW'(v1); r.o1 = o1;
        r.k2 = k2; r.v2 = DW'(v2); r.o2 = o2;
        tbl.push_back(r);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        if (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input bit b2b);
        for (int j = 0; j < s.len(); j++) send_byte(s[j], !b2b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every pulse must match the head of that DUT's queue.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (nv[d] || ne[d]) begin
                exp_t e;
                check("valid_err_exclusive", d, longint'(nv[d] && ne[d]), 0);
                if (expq[d].size() == 0) begin
                    check("unexpected_event", d, nv[d] ? K_V : K_E, K_N);
                end else begin
                    e = expq[d].pop_front();
                    check("event_kind", d, nv[d] ? K_V : K_E, e.kind);
                    check("num_value", d, val[d], e.val);
                    check("num_ovf", d, no[d], e.ovf);
                    if (e.cyc >= 0) check("latency", d, cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        longint c0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cnt_clr = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            mdl_val[d] = '0;
            mdl_tok[d] = '0;
        end

        //   text          b2b  A: kind val ovf       B: kind val ovf      C: kind val ovf
        add("10 ",         0,  K_V, 10,     0,     K_V, 10,     0,     K_V, 10,     0);
        add("20 ",         0,  K_V, 20,     0,     K_V, 20,     0,     K_V, 20,     0);
        add("-32768,",     0,  K_V, 'h8000, 0,     K_V, 'h8000, 0,     K_E, 0,      0);
        add("32767\r",     0,  K_V, 'h7FFF, 0,     K_V, 'h7FFF, 0,     K_V, 'h7FFF, 0);
        add("-32769 ",     0,  K_V, 'h8000, 1,     K_E, 0,      0,     K_E, 0,      0);
        add("99999 ",      0,  K_V, 'h7FFF, 1,     K_E, 0,      0,     K_V, 'hFFFF, 1);
        add("12a4 ",       0,  K_E, 0,      0,     K_E, 0,      0,     K_E, 0,      0);
        add("5 ",          0,  K_V, 5,      0,     K_V, 5,      0,     K_V, 5,      0);
        add("   - ",       0,  K_E, 0,      0,     K_E, 0,      0,     K_E, 0,      0);
        add("7 ",          0,  K_V, 7,      0,     K_V, 7,      0,     K_V, 7,      0);
        add("-7 ",         0,  K_V, 'hFFF9, 0,     K_V, 'hFFF9, 0,     K_E, 0,      0);
        add("123456 ",     0,  K_V, 'h7FFF, 1,     K_E, 0,      0,     K_V, 'hFFFF, 1);
        add("65535\n",     0,  K_V, 'h7FFF, 1,     K_E, 0,      0,     K_V, 'hFFFF, 0);
        add("0,,, \r\n",   0,  K_V, 0,      0,     K_V, 0,      0,     K_V, 0,      0);
        add("--3 ",        0,  K_E, 0,      0,     K_E, 0,      0,     K_E, 0,      0);
        add("00042 ",      1,  K_V, 42,     0,     K_V, 42,     0,     K_V, 42,     0);

        idle(3);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_num_valid", d, nv[d], 0);
            check("reset_num_err", d, ne[d], 0);
            check("reset_num_ovf", d, no[d], 0);
            check("reset_busy", d, bz[d], 0);
            check("reset_num_value", d, val[d], 0);
            check("reset_tok_cnt", d, tc[d], 0);
        end
        rst = 1'b0;
        idle(2);

        foreach (tbl[i]) begin
            push_ev(0, tbl[i].k0, tbl[i].v0, tbl[i].o0, -1);
            push_ev(1, tbl[i].k1, tbl[i].v1, tbl[i].o1, -1);
            push_ev(2, tbl[i].k2, tbl[i].v2, tbl[i].o2, -1);
            send_str(tbl[i].txt, tbl[i].b2b);
        end
        idle(4);
        for (int d = 0; d < NDUT; d++) begin
            check("tok_cnt_after_table", d, tc[d], mdl_tok[d]);
            check("pending_after_table", d, expq[d].size(), 0);
        end

        // Delimiter latency and busy flag.
        send_byte("7", 1);
        for (int d = 0; d < NDUT; d++) check("busy_in_token", d, bz[d], 1);
        send_byte("7", 1);
        c0 = cyc;
        for (int d = 0; d < NDUT; d++) push_ev(d, K_V, 77, 0, c0 + 1);
        send_byte(" ", 1);
        for (int d = 0; d < NDUT; d++) check("busy_after_token", d, bz[d], 0);

        // cnt_clr coinciding with an emit: clear wins.
        send_byte("8", 1);
        for (int d = 0; d < NDUT; d++) push_ev(d, K_V, 8, 0, -1);
        rx_valid = 1'b1; rx_data = " "; cnt_clr = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'h00; cnt_clr = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            mdl_tok[d] = '0;
            check("tok_cnt_clear_wins", d, tc[d], mdl_tok[d]);
        end
        for (int d = 0; d < NDUT; d++) push_ev(d, K_V, 9, 0, -1);
        send_str("9 ", 0);
        for (int d = 0; d < NDUT; d++) check("tok_cnt_after_clear", d, tc[d], mdl_tok[d]);

        // Idle timeout flushes "42" exactly 100 cycles after its last byte.
        send_byte("4", 1);
        c0 = cyc;
        push_ev(0, K_V, 42, 0, c0 + 100);
        push_ev(1, K_V, 42, 0, c0 + 100);
        send_byte("2", 1);
        idle(110);
        check("busy_after_timeout", 0, bz[0], 0);
        check("busy_no_timeout", 2, bz[2], 1);
        push_ev(2, K_V, 42, 0, -1);
        send_byte(8'h0D, 1);

        // Timeout on a lone '-' is an error.
        c0 = cyc;
        push_ev(0, K_E, 0, 0, c0 + 100);
        push_ev(1, K_E, 0, 0, c0 + 100);
        send_byte("-", 1);
        idle(110);
        push_ev(2, K_E, 0, 0, -1);
        send_byte(" ", 1);
        idle(2);
        for (int d = 0; d < NDUT; d++) check("pending_before_reset", d, expq[d].size(), 0);

        // Reset while the third digit of "123" arrives: token dropped silently.
        send_str("12", 0);
        rx_valid = 1'b1; rx_data = "3"; rst = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            mdl_val[d] = '0;
            mdl_tok[d] = '0;
            check("midtoken_reset_busy", d, bz[d], 0);
            check("midtoken_reset_value", d, val[d], mdl_val[d]);
            check("midtoken_reset_tok_cnt", d, tc[d], mdl_tok[d]);
        end
        idle(2);
        for (int d = 0; d < NDUT; d++) push_ev(d, K_V, 5, 0, -1);
        send_str("5 ", 0);
        idle(5);

        for (int d = 0; d < NDUT; d++) begin
            check("final_tok_cnt", d, tc[d], mdl_tok[d]);
            check("pending_at_end", d, expq[d].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
